// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the PC register and chooses sequential, branch
// (via the external registered adder) or jump targets; drives IF/ID qualifiers.
module fetch_pc_ctrl #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_req,
  input  logic [WIDTH-1:0] branch_pc4,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             jump_req,
  input  logic [WIDTH-1:0] jump_tgt,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_q,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [0:0] {RUN, BR_WAIT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic             run_go, jmp_take, br_take;

  // Requests are only meaningful in RUN while not stalled; a jump beats a branch.
  assign run_go   = (state == RUN) && !stall;
  assign jmp_take = run_go && jump_req;
  assign br_take  = run_go && branch_req && !jump_req;

  assign pc_plus4 = pc + WIDTH'(4);

  // The live operands feed the adder on the request cycle; afterwards the
  // captured copies keep it stable through BR_WAIT.
  assign add_a = (run_go && branch_req) ? branch_pc4 : op_a;
  assign add_b = (run_go && branch_req) ? branch_off : op_b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (br_take) state_nxt = BR_WAIT;
      BR_WAIT: if (!stall)  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    fetch_valid = 1'b0;
    flush       = 1'b0;
    if (!rst && state == RUN && !stall) begin
      flush       = jump_req || branch_req;
      fetch_valid = !(jump_req || branch_req);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      op_a         <= '0;
      op_b         <= '0;
      redirect_cnt <= '0;
    end else begin
      if (br_take) begin
        op_a <= branch_pc4;
        op_b <= branch_off;
      end
      if ((jmp_take || br_take) && redirect_cnt != '1)
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (state == RUN && !stall) begin
        if (jmp_take)      pc <= jump_tgt;
        else if (!br_take) pc <= pc_plus4;
      end else if (state == BR_WAIT && !stall) begin
        pc <= add_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares against the DUT and a modelled adder.
module tb_fetch_pc_ctrl;

  localparam int W = 32;
  localparam int C = 3;

  logic         clk = 1'b0;
  logic         rst, stall, branch_req, jump_req;
  logic [W-1:0] branch_pc4, branch_off, jump_tgt;
  logic [W-1:0] add_a, add_b, add_q, pc, pc_plus4;
  logic         fetch_valid, flush;
  logic [C-1:0] redirect_cnt;

  typedef struct {
    string        name;
    logic [W-1:0] pc, a, b;
    logic         fv, fl;
    logic [C-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  always #5 clk = ~clk;

  // Model of the external registered branch-target adder sharing rst.
  always_ff @(posedge clk) begin
    if (rst) add_q <= '0;
    else     add_q <= add_a + add_b;
  end

  fetch_pc_ctrl #(.WIDTH(W), .RESET_PC(32'h0000_0000), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_req(branch_req), .branch_pc4(branch_pc4), .branch_off(branch_off),
    .jump_req(jump_req), .jump_tgt(jump_tgt),
    .add_a(add_a), .add_b(add_b), .add_q(add_q),
    .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .flush(flush), .redirect_cnt(redirect_cnt)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle that has a pending expectation is compared here.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".pc"}, pc, e.pc);
        check({e.name, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
        check({e.name, ".add_a"}, add_a, e.a);
        check({e.name, ".add_b"}, add_b, e.b);
        check({e.name, ".flush"}, W'(flush), W'(e.fl));
        check({e.name, ".cnt"}, W'(redirect_cnt), W'(e.cnt));
        if (!$isunknown(e.fv)) check({e.name, ".fetch_valid"}, W'(fetch_valid), W'(e.fv));
      end
    end
  end

  task automatic step(input string name, input logic r, input logic s,
                      input logic br, input logic [W-1:0] pc4, input logic [W-1:0] off,
                      input logic jr, input logic [W-1:0] tgt,
                      input logic [W-1:0] e_pc, input logic e_fv, input logic e_fl,
                      input logic [W-1:0] e_a, input logic [W-1:0] e_b, input logic [C-1:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = s; branch_req = br; branch_pc4 = pc4; branch_off = off;
    jump_req = jr; jump_tgt = tgt;
    e.name = name; e.pc = e_pc; e.fv = e_fv; e.fl = e_fl; e.a = e_a; e.b = e_b; e.cnt = e_cnt;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_req = 1'b0; jump_req = 1'b0;
    branch_pc4 = '0; branch_off = '0; jump_tgt = '0;
    //   name          rst s  br pc4          off          jr tgt          | pc           fv    fl add_a  add_b        cnt
    step("reset",      1, 0, 0, 0,           0,           0, 0,           32'h0,        0,    0, 0,     0,           0);
    step("seq0",       0, 0, 0, 0,           0,           0, 0,           32'h0,        1,    0, 0,     0,           0);
    step("seq4",       0, 0, 0, 0,           0,           0, 0,           32'h4,        1,    0, 0,     0,           0);
    step("seq8",       0, 0, 0, 0,           0,           0, 0,           32'h8,        1,    0, 0,     0,           0);
    step("seqc",       0, 0, 0, 0,           0,           0, 0,           32'hC,        1,    0, 0,     0,           0);
    step("br_issue",   0, 0, 1, 32'h10,      32'h20,      0, 0,           32'h10,       0,    1, 32'h10, 32'h20,     0);
    step("br_wait",    0, 0, 0, 0,           0,           0, 0,           32'h10,       0,    0, 32'h10, 32'h20,     1);
    step("br_tgt",     0, 0, 0, 0,           0,           0, 0,           32'h30,       1,    0, 32'h10, 32'h20,     1);
    step("br2_issue",  0, 0, 1, 32'h10,      32'h20,      0, 0,           32'h34,       0,    1, 32'h10, 32'h20,     1);
    step("br2_stall0", 0, 1, 1, 32'h999,     32'h1,       1, 32'h800,     32'h34,       0,    0, 32'h10, 32'h20,     2);
    step("br2_stall1", 0, 1, 1, 32'h999,     32'h1,       1, 32'h800,     32'h34,       0,    0, 32'h10, 32'h20,     2);
    step("br2_stall2", 0, 1, 1, 32'h999,     32'h1,       1, 32'h800,     32'h34,       0,    0, 32'h10, 32'h20,     2);
    step("br2_go",     0, 0, 1, 32'h999,     32'h1,       1, 32'h800,     32'h34,       0,    0, 32'h10, 32'h20,     2);
    step("jmp_and_br", 0, 0, 1, 32'h50,      32'h100,     1, 32'h400,     32'h30,       1'bx, 1, 32'h50, 32'h100,    2);
    step("stall_jmp",  0, 1, 0, 0,           0,           1, 32'h800,     32'h400,      0,    0, 32'h10, 32'h20,     3);
    step("post_jmp",   0, 0, 0, 0,           0,           0, 0,           32'h400,      1,    0, 32'h10, 32'h20,     3);
    step("jmp_hi",     0, 0, 0, 0,           0,           1, 32'hFFFFFFF8, 32'h404,     1'bx, 1, 32'h10, 32'h20,     3);
    step("wrap_f8",    0, 0, 0, 0,           0,           0, 0,           32'hFFFFFFF8, 1,    0, 32'h10, 32'h20,     4);
    step("wrap_fc",    0, 0, 0, 0,           0,           0, 0,           32'hFFFFFFFC, 1,    0, 32'h10, 32'h20,     4);
    step("wrap_0_br",  0, 0, 1, 32'h4,       32'hFFFFFFF8, 0, 0,          32'h0,        0,    1, 32'h4,  32'hFFFFFFF8, 4);
    step("brwrap_wt",  0, 0, 0, 0,           0,           0, 0,           32'h0,        0,    0, 32'h4,  32'hFFFFFFF8, 5);
    step("brwrap_tgt", 0, 0, 0, 0,           0,           1, 32'h100,     32'hFFFFFFFC, 1'bx, 1, 32'h4,  32'hFFFFFFF8, 5);
    step("sat_j1",     0, 0, 0, 0,           0,           1, 32'h200,     32'h100,      1'bx, 1, 32'h4,  32'hFFFFFFF8, 6);
    step("sat_j2",     0, 0, 0, 0,           0,           1, 32'h300,     32'h200,      1'bx, 1, 32'h4,  32'hFFFFFFF8, 7);
    step("sat_br",     0, 0, 1, 32'h304,     32'h40,      0, 0,           32'h300,      0,    1, 32'h304, 32'h40,    7);
    step("rst_in_wait",1, 0, 0, 0,           0,           0, 0,           32'h300,      0,    0, 32'h304, 32'h40,    7);
    step("post_rst",   0, 0, 0, 0,           0,           0, 0,           32'h0,        1,    0, 0,     0,           0);
    step("post_rst4",  0, 0, 0, 0,           0,           0, 0,           32'h4,        1,    0, 0,     0,           0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    check("drain", W'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
